decode_stage: RTL and testbench

- Registered, parametrised successor to the single-issue RV decoder.
- Decodes LOAD, LOAD_FP, STORE, STORE_FP, OP_IMM, LUI and AUIPC for RV32 or RV64 (XLEN), with optional double-precision FP (FLEN).
- Sits between fetch and issue, with valid/ready handshakes on both sides, a 2-entry skid buffer, a pipeline flush and a saturating illegal-instruction counter.
- Opcode and subcode constants come from the instruction_utilities package.

---
 rtl/decode_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : decode_stage (with package instruction_utilities)
// Purpose  : Registered RV32/RV64 decoder for LOAD, LOAD_FP, STORE, STORE_FP,
//            OP_IMM, LUI and AUIPC. Sits between fetch and issue with
//            valid/ready handshakes, a 2-entry skid buffer (output register
//            plus one skid entry), a flush input and a saturating counter of
//            accepted illegal instructions.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_valid/in_ready - fetch handshake, instruction[31:0] payload
//            flush             - discard every held and incoming instruction
//            out_valid/out_ready - issue handshake
//            inst_type[3:0]    - {alu_in, fpu_in, fpu_sd, mem_in}
//            alu_op[6:0], mem_op[5:0] - operation subcodes
//            reg_d, reg_s1, reg_s2 - register indices
//            immed[XLEN-1:0]   - sign-extended immediate
//            bad_inst          - illegal/unimplemented encoding
//            bad_count[CNT_W-1:0] - illegal instructions accepted since reset
// Revision : 1.0 - initial release
// ============================================================================

package instruction_utilities;
   // Major opcodes
   localparam logic [6:0] c_opc_load     = 7'b0000011;
   localparam logic [6:0] c_opc_load_fp  = 7'b0000111;
   localparam logic [6:0] c_opc_store    = 7'b0100011;
   localparam logic [6:0] c_opc_store_fp = 7'b0100111;
   localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
   localparam logic [6:0] c_opc_lui      = 7'b0110111;
   localparam logic [6:0] c_opc_auipc    = 7'b0010111;

   // ALU subcodes
   localparam logic [6:0] c_alu_addi  = 7'd1;
   localparam logic [6:0] c_alu_slti  = 7'd2;
   localparam logic [6:0] c_alu_sltiu = 7'd3;
   localparam logic [6:0] c_alu_xori  = 7'd4;
   localparam logic [6:0] c_alu_ori   = 7'd5;
   localparam logic [6:0] c_alu_andi  = 7'd6;
   localparam logic [6:0] c_alu_slli  = 7'd7;
   localparam logic [6:0] c_alu_srli  = 7'd8;
   localparam logic [6:0] c_alu_srai  = 7'd9;
   localparam logic [6:0] c_alu_lui   = 7'd10;
   localparam logic [6:0] c_alu_auipc = 7'd11;

   // Memory subcodes
   localparam logic [5:0] c_mem_lb  = 6'd1;
   localparam logic [5:0] c_mem_lh  = 6'd2;
   localparam logic [5:0] c_mem_lw  = 6'd3;
   localparam logic [5:0] c_mem_ld  = 6'd4;
   localparam logic [5:0] c_mem_lbu = 6'd5;
   localparam logic [5:0] c_mem_lhu = 6'd6;
   localparam logic [5:0] c_mem_lwu = 6'd7;
   localparam logic [5:0] c_mem_sb  = 6'd8;
   localparam logic [5:0] c_mem_sh  = 6'd9;
   localparam logic [5:0] c_mem_sw  = 6'd10;
   localparam logic [5:0] c_mem_sd  = 6'd11;
   localparam logic [5:0] c_mem_flw = 6'd12;
   localparam logic [5:0] c_mem_fld = 6'd13;
   localparam logic [5:0] c_mem_fsw = 6'd14;
   localparam logic [5:0] c_mem_fsd = 6'd15;
endpackage

module decode_stage
   import instruction_utilities::*;
#(
   parameter int XLEN  = 32,
   parameter int FLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       inst_type,
   output logic [6:0]       alu_op,
   output logic [5:0]       mem_op,
   output logic [4:0]       reg_d,
   output logic [4:0]       reg_s1,
   output logic [4:0]       reg_s2,
   output logic [XLEN-1:0]  immed,
   output logic             bad_inst,
   output logic [CNT_W-1:0] bad_count
);

   typedef struct packed {
      logic [3:0]      itype;
      logic [6:0]      alu;
      logic [5:0]      mem;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic            bad;
   } bundle_t;

   // ------------------------------------------------------------------------
   // Combinational decode of the incoming word
   // ------------------------------------------------------------------------
   logic [6:0]      w_opc;
   logic [2:0]      w_f3;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_u;
   logic            w_sh_plain;   // shift upper bits all zero
   logic            w_sh_arith;   // shift upper bits encode SRAI
   logic            w_ok;
   bundle_t         w_raw;
   bundle_t         w_dec;

   assign w_opc   = instruction[6:0];
   assign w_f3    = instruction[14:12];
   assign w_imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
   assign w_imm_s = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign w_imm_u = {{(XLEN-31){instruction[31]}}, instruction[30:12], 12'b0};

   // RV64 shift amounts are 6 bits wide, so one fewer funct bit is checked.
   assign w_sh_plain = (XLEN == 64) ? (instruction[31:26] == 6'b000000)
                                    : (instruction[31:25] == 7'b0000000);
   assign w_sh_arith = (XLEN == 64) ? (instruction[31:26] == 6'b010000)
                                    : (instruction[31:25] == 7'b0100000);

   always_comb begin
      w_raw = '0;
      w_ok  = 1'b0;
      unique case (w_opc)
         c_opc_load: begin
            w_raw.itype = 4'b0001;
            w_raw.rd    = instruction[11:7];
            w_raw.rs1   = instruction[19:15];
            w_raw.imm   = w_imm_i;
            w_ok        = 1'b1;
            unique case (w_f3)
               3'b000:  w_raw.mem = c_mem_lb;
               3'b001:  w_raw.mem = c_mem_lh;
               3'b010:  w_raw.mem = c_mem_lw;
               3'b011: begin
                  w_raw.mem = c_mem_ld;
                  w_ok      = (XLEN == 64);
               end
               3'b100:  w_raw.mem = c_mem_lbu;
               3'b101:  w_raw.mem = c_mem_lhu;
               3'b110: begin
                  w_raw.mem = c_mem_lwu;
                  w_ok      = (XLEN == 64);
               end
               default: w_ok = 1'b0;
            endcase
         end
         c_opc_load_fp: begin
            w_raw.rd  = instruction[11:7];
            w_raw.rs1 = instruction[19:15];
            w_raw.imm = w_imm_i;
            if (w_f3 == 3'b010) begin
               w_raw.itype = 4'b0101;
               w_raw.mem   = c_mem_flw;
               w_ok        = 1'b1;
            end else if (w_f3 == 3'b011) begin
               w_raw.itype = 4'b0111;
               w_raw.mem   = c_mem_fld;
               w_ok        = (FLEN == 64);
            end
         end
         c_opc_store: begin
            w_raw.itype = 4'b0001;
            w_raw.rs1   = instruction[19:15];
            w_raw.rs2   = instruction[24:20];
            w_raw.imm   = w_imm_s;
            w_ok        = 1'b1;
            unique case (w_f3)
               3'b000:  w_raw.mem = c_mem_sb;
               3'b001:  w_raw.mem = c_mem_sh;
               3'b010:  w_raw.mem = c_mem_sw;
               3'b011: begin
                  w_raw.mem = c_mem_sd;
                  w_ok      = (XLEN == 64);
               end
               default: w_ok = 1'b0;
            endcase
         end
         c_opc_store_fp: begin
            w_raw.rs1 = instruction[19:15];
            w_raw.rs2 = instruction[24:20];
            w_raw.imm = w_imm_s;
            if (w_f3 == 3'b010) begin
               w_raw.itype = 4'b0101;
               w_raw.mem   = c_mem_fsw;
               w_ok        = 1'b1;
            end else if (w_f3 == 3'b011) begin
               w_raw.itype = 4'b0111;
               w_raw.mem   = c_mem_fsd;
               w_ok        = (FLEN == 64);
            end
         end
         c_opc_op_imm: begin
            w_raw.itype = 4'b1000;
            w_raw.rd    = instruction[11:7];
            w_raw.rs1   = instruction[19:15];
            w_raw.imm   = w_imm_i;
            w_ok        = 1'b1;
            unique case (w_f3)
               3'b000: w_raw.alu = c_alu_addi;
               3'b001: begin
                  w_raw.alu = c_alu_slli;
                  w_ok      = w_sh_plain;
               end
               3'b010: w_raw.alu = c_alu_slti;
               3'b011: w_raw.alu = c_alu_sltiu;
               3'b100: w_raw.alu = c_alu_xori;
               3'b101: begin
                  // Bit 30 distinguishes the arithmetic right shift.
                  w_raw.alu = instruction[30] ? c_alu_srai : c_alu_srli;
                  w_ok      = instruction[30] ? w_sh_arith : w_sh_plain;
               end
               3'b110: w_raw.alu = c_alu_ori;
               default: w_raw.alu = c_alu_andi;
            endcase
         end
         c_opc_lui: begin
            w_raw.itype = 4'b1000;
            w_raw.alu   = c_alu_lui;
            w_raw.rd    = instruction[11:7];
            w_raw.imm   = w_imm_u;
            w_ok        = 1'b1;
         end
         c_opc_auipc: begin
            w_raw.itype = 4'b1000;
            w_raw.alu   = c_alu_auipc;
            w_raw.rd    = instruction[11:7];
            w_raw.imm   = w_imm_u;
            w_ok        = 1'b1;
         end
         default: w_ok = 1'b0;
      endcase
      if (instruction[1:0] != 2'b11) begin
         w_ok = 1'b0;
      end
   end

   // An illegal word still travels down the pipe, but as an empty bundle.
   always_comb begin
      w_dec = w_raw;
      if (!w_ok) begin
         w_dec     = '0;
         w_dec.bad = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Output register (OR) and skid entry (SK)
   // ------------------------------------------------------------------------
   bundle_t          r_or;
   bundle_t          r_sk;
   logic             r_or_v;
   logic             r_sk_v;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_bad_cnt;

   logic    w_acc;
   logic    w_cons;
   logic    w_cnt_inc;
   bundle_t w_or_nxt;
   bundle_t w_sk_nxt;
   logic    w_or_v_nxt;
   logic    w_sk_v_nxt;

   assign w_acc     = in_valid && r_in_ready;
   assign w_cons    = r_or_v && out_ready;
   assign w_cnt_inc = w_acc && w_dec.bad && (r_bad_cnt != {CNT_W{1'b1}});

   // in_ready is low whenever SK is full, so an accept never coincides with
   // an SK-to-OR move; the two branches below can therefore not collide.
   always_comb begin
      w_or_nxt   = r_or;
      w_sk_nxt   = r_sk;
      w_or_v_nxt = r_or_v;
      w_sk_v_nxt = r_sk_v;
      if (w_cons) begin
         if (r_sk_v) begin
            w_or_nxt   = r_sk;
            w_sk_nxt   = '0;
            w_sk_v_nxt = 1'b0;
         end else if (w_acc) begin
            w_or_nxt = w_dec;
         end else begin
            w_or_v_nxt = 1'b0;
         end
      end else if (w_acc) begin
         if (!r_or_v) begin
            w_or_nxt   = w_dec;
            w_or_v_nxt = 1'b1;
         end else begin
            w_sk_nxt   = w_dec;
            w_sk_v_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_or       <= '0;
         r_sk       <= '0;
         r_or_v     <= 1'b0;
         r_sk_v     <= 1'b0;
         r_in_ready <= 1'b0;
         r_bad_cnt  <= '0;
      end else if (flush) begin
         // Anything accepted in this cycle is dropped and not counted.
         r_or       <= '0;
         r_sk       <= '0;
         r_or_v     <= 1'b0;
         r_sk_v     <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         r_or       <= w_or_nxt;
         r_sk       <= w_sk_nxt;
         r_or_v     <= w_or_v_nxt;
         r_sk_v     <= w_sk_v_nxt;
         r_in_ready <= !w_sk_v_nxt;
         if (w_cnt_inc) begin
            r_bad_cnt <= r_bad_cnt + 1'b1;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_or_v;
   assign inst_type = r_or.itype;
   assign alu_op    = r_or.alu;
   assign mem_op    = r_or.mem;
   assign reg_d     = r_or.rd;
   assign reg_s1    = r_or.rs1;
   assign reg_s2    = r_or.rs2;
   assign immed     = r_or.imm;
   assign bad_inst  = r_or.bad;
   assign bad_count = r_bad_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Scoreboard bench for decode_stage. Two instances share one
//            stimulus stream: A is RV64 with double FP, B is RV32 with single
//            FP and a 3-bit illegal counter so saturation is reached quickly.
//            Expected bundles come from a rule-level reference decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
   import instruction_utilities::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] instruction = 32'h0;

   always #5 clk = ~clk;

   logic        in_ready_a, out_valid_a, bad_inst_a;
   logic [3:0]  inst_type_a;
   logic [6:0]  alu_op_a;
   logic [5:0]  mem_op_a;
   logic [4:0]  reg_d_a, reg_s1_a, reg_s2_a;
   logic [63:0] immed_a;
   logic [15:0] bad_count_a;

   logic        in_ready_b, out_valid_b, bad_inst_b;
   logic [3:0]  inst_type_b;
   logic [6:0]  alu_op_b;
   logic [5:0]  mem_op_b;
   logic [4:0]  reg_d_b, reg_s1_b, reg_s2_b;
   logic [31:0] immed_b;
   logic [2:0]  bad_count_b;

   decode_stage #(.XLEN(64), .FLEN(64), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .instruction(instruction), .flush(flush), .out_valid(out_valid_a),
      .out_ready(out_ready), .inst_type(inst_type_a), .alu_op(alu_op_a),
      .mem_op(mem_op_a), .reg_d(reg_d_a), .reg_s1(reg_s1_a), .reg_s2(reg_s2_a),
      .immed(immed_a), .bad_inst(bad_inst_a), .bad_count(bad_count_a)
   );

   decode_stage #(.XLEN(32), .FLEN(32), .CNT_W(3)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .instruction(instruction), .flush(flush), .out_valid(out_valid_b),
      .out_ready(out_ready), .inst_type(inst_type_b), .alu_op(alu_op_b),
      .mem_op(mem_op_b), .reg_d(reg_d_b), .reg_s1(reg_s1_b), .reg_s2(reg_s2_b),
      .immed(immed_b), .bad_inst(bad_inst_b), .bad_count(bad_count_b)
   );

   typedef struct packed {
      logic [3:0]  it;
      logic [6:0]  alu;
      logic [5:0]  mem;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [63:0] imm;
      logic        bad;
   } exp_t;

   typedef struct packed {
      exp_t a;
      exp_t b;
   } pair_t;

   pair_t       sbq[$];
   logic [15:0] cnt_a = 16'd0;
   logic [2:0]  cnt_b = 3'd0;
   logic        in_rst_m = 1'b1;
   logic        done = 1'b0;
   int          checks = 0;
   int          errors = 0;

   // Subcode tables indexed by funct3; zero marks an unused slot.
   logic [5:0] load_tab  [8] = '{c_mem_lb, c_mem_lh, c_mem_lw, c_mem_ld,
                                 c_mem_lbu, c_mem_lhu, c_mem_lwu, 6'd0};
   logic [5:0] store_tab [8] = '{c_mem_sb, c_mem_sh, c_mem_sw, c_mem_sd,
                                 6'd0, 6'd0, 6'd0, 6'd0};
   logic [6:0] alu_tab   [8] = '{c_alu_addi, c_alu_slli, c_alu_slti, c_alu_sltiu,
                                 c_alu_xori, c_alu_srli, c_alu_ori, c_alu_andi};
   logic [6:0] op_tab    [7] = '{c_opc_load, c_opc_load_fp, c_opc_store,
                                 c_opc_store_fp, c_opc_op_imm, c_opc_lui, c_opc_auipc};

   function automatic exp_t ref_dec(input logic [31:0] w, input int xlen, input int flen);
      exp_t        e;
      logic        ok;
      int          f3;
      int          shw;
      int          upper;
      logic [63:0] imm_i, imm_s, imm_u;
      e     = '0;
      ok    = 1'b0;
      f3    = int'(w[14:12]);
      imm_i = {{52{w[31]}}, w[31:20]};
      imm_s = {{52{w[31]}}, w[31:25], w[11:7]};
      imm_u = {{32{w[31]}}, w[31:12], 12'h000};
      if (w[1:0] == 2'b11) begin
         if (w[6:0] == c_opc_load) begin
            e.it = 4'b0001; e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = imm_i;
            e.mem = load_tab[f3];
            ok = (load_tab[f3] != 6'd0) && (xlen == 64 || !(f3 == 3 || f3 == 6));
         end else if (w[6:0] == c_opc_store) begin
            e.it = 4'b0001; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = imm_s;
            e.mem = store_tab[f3];
            ok = (store_tab[f3] != 6'd0) && (xlen == 64 || f3 != 3);
         end else if (w[6:0] == c_opc_load_fp || w[6:0] == c_opc_store_fp) begin
            if (w[6:0] == c_opc_load_fp) begin
               e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = imm_i;
               e.mem = (f3 == 2) ? c_mem_flw : c_mem_fld;
            end else begin
               e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = imm_s;
               e.mem = (f3 == 2) ? c_mem_fsw : c_mem_fsd;
            end
            e.it = (f3 == 2) ? 4'b0101 : 4'b0111;
            ok = (f3 == 2) || (f3 == 3 && flen == 64);
         end else if (w[6:0] == c_opc_op_imm) begin
            e.it = 4'b1000; e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = imm_i;
            e.alu = (f3 == 5 && w[30]) ? c_alu_srai : alu_tab[f3];
            if (f3 == 1 || f3 == 5) begin
               shw   = (xlen == 64) ? 6 : 5;
               upper = int'(w[31:20]) >> shw;
               ok = (upper == 0) || (f3 == 5 && upper == ((xlen == 64) ? 16 : 32));
            end else begin
               ok = 1'b1;
            end
         end else if (w[6:0] == c_opc_lui || w[6:0] == c_opc_auipc) begin
            e.it = 4'b1000; e.rd = w[11:7]; e.imm = imm_u;
            e.alu = (w[6:0] == c_opc_lui) ? c_alu_lui : c_alu_auipc;
            ok = 1'b1;
         end
      end
      if (!ok) begin
         e     = '0;
         e.bad = 1'b1;
      end
      if (xlen == 32) e.imm[63:32] = 32'h0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_bundle(input string tag, input exp_t e, input logic [3:0] it,
                             input logic [6:0] alu, input logic [5:0] mem,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [63:0] imm,
                             input logic bad);
      chk({tag, ".inst_type"}, 64'(it), 64'(e.it));
      chk({tag, ".alu_op"}, 64'(alu), 64'(e.alu));
      chk({tag, ".mem_op"}, 64'(mem), 64'(e.mem));
      chk({tag, ".reg_d"}, 64'(rd), 64'(e.rd));
      chk({tag, ".reg_s1"}, 64'(rs1), 64'(e.rs1));
      chk({tag, ".reg_s2"}, 64'(rs2), 64'(e.rs2));
      chk({tag, ".immed"}, imm, e.imm);
      chk({tag, ".bad_inst"}, 64'(bad), 64'(e.bad));
   endtask

   // Monitor: queue contents at the falling edge are exactly what the stage
   // holds, so occupancy, handshake outputs and the head bundle follow from it.
   always @(negedge clk) begin
      if (!done) begin
         chk("in_ready_a", 64'(in_ready_a), 64'(!in_rst_m && sbq.size() < 2));
         chk("in_ready_b", 64'(in_ready_b), 64'(!in_rst_m && sbq.size() < 2));
         chk("out_valid_a", 64'(out_valid_a), 64'(!in_rst_m && sbq.size() > 0));
         chk("out_valid_b", 64'(out_valid_b), 64'(!in_rst_m && sbq.size() > 0));
         chk("bad_count_a", 64'(bad_count_a), 64'(cnt_a));
         chk("bad_count_b", 64'(bad_count_b), 64'(cnt_b));
         if (in_rst_m) begin
            chk("rst_type_a", 64'(inst_type_a), 64'd0);
            chk("rst_immed_a", immed_a, 64'd0);
            chk("rst_bad_b", 64'(bad_inst_b), 64'd0);
         end
         if (sbq.size() > 0 && out_valid_a && out_valid_b) begin
            cmp_bundle("A", sbq[0].a, inst_type_a, alu_op_a, mem_op_a, reg_d_a,
                       reg_s1_a, reg_s2_a, immed_a, bad_inst_a);
            cmp_bundle("B", sbq[0].b, inst_type_b, alu_op_b, mem_op_b, reg_d_b,
                       reg_s1_b, reg_s2_b, 64'(immed_b), bad_inst_b);
         end
         if (!rst && !flush && out_ready && sbq.size() > 0) begin
            void'(sbq.pop_front());
         end
      end
   end

   // One clock of stimulus; returns one time unit after the rising edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                       input logic fl, input logic r);
      logic  acc;
      pair_t p;
      rst         = r;
      in_valid    = v;
      instruction = ins;
      out_ready   = ordy;
      flush       = fl;
      acc         = v && (in_ready_a === 1'b1) && !fl && !r;
      p.a         = ref_dec(ins, 64, 64);
      p.b         = ref_dec(ins, 32, 32);
      @(posedge clk);
      #1;
      if (r) begin
         sbq.delete();
         cnt_a    = 16'd0;
         cnt_b    = 3'd0;
         in_rst_m = 1'b1;
      end else begin
         in_rst_m = 1'b0;
         if (fl) begin
            sbq.delete();
         end else if (acc) begin
            sbq.push_back(p);
            if (p.a.bad && cnt_a != 16'hFFFF) cnt_a = cnt_a + 16'd1;
            if (p.b.bad && cnt_b != 3'd7) cnt_b = cnt_b + 3'd1;
         end
      end
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      int unsigned k;
      w = $urandom;
      k = $urandom_range(0, 7);
      if (k < 7) w[6:0] = op_tab[k];
      if (w[6:0] == c_opc_op_imm) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'b0000000;
            1: w[31:25] = 7'b0100000;
            2: w[31:26] = 6'b000000;
            default: ;
         endcase
      end
      if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 3));
      return w;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] sv_a;
      logic [2:0]  sv_b;

      // Reset for two cycles
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("rst_in_ready", 64'(in_ready_a), 64'd0);
      chk("rst_out_valid", 64'(out_valid_a), 64'd0);
      chk("rst_bad_count", 64'(bad_count_a), 64'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_in_ready", 64'(in_ready_a), 64'd1);

      // LW x5,-4(x2)
      step(1'b1, 32'hFFC12283, 1'b1, 1'b0, 1'b0);
      chk("lw_valid", 64'(out_valid_a), 64'd1);
      chk("lw_type", 64'(inst_type_a), 64'h1);
      chk("lw_rd", 64'(reg_d_a), 64'd5);
      chk("lw_rs1", 64'(reg_s1_a), 64'd2);
      chk("lw_immed", immed_a, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("lw_bad", 64'(bad_inst_a), 64'd0);

      // LD x1,0(x0): illegal on RV32 only
      step(1'b1, 32'h00003083, 1'b1, 1'b0, 1'b0);
      chk("ld32_bad", 64'(bad_inst_b), 64'd1);
      chk("ld32_type", 64'(inst_type_b), 64'd0);
      chk("ld32_count", 64'(bad_count_b), 64'd1);
      chk("ld64_bad", 64'(bad_inst_a), 64'd0);
      chk("ld64_count", 64'(bad_count_a), 64'd0);

      // LUI x7,0x80000
      step(1'b1, 32'h800003B7, 1'b1, 1'b0, 1'b0);
      chk("lui_type", 64'(inst_type_a), 64'h8);
      chk("lui_rd", 64'(reg_d_a), 64'd7);
      chk("lui_immed", immed_a, 64'hFFFF_FFFF_8000_0000);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Back-pressure: three ADDIs into a stalled stage
      step(1'b1, 32'h00A00093, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00A00113, 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready_low", 64'(in_ready_a), 64'd0);
      step(1'b1, 32'h00A00193, 1'b0, 1'b0, 1'b0);
      chk("bp_still_full", 64'(in_ready_a), 64'd0);
      chk("bp_head_first", 64'(reg_d_a), 64'd1);
      step(1'b1, 32'h00A00193, 1'b1, 1'b0, 1'b0);
      chk("bp_head_second", 64'(reg_d_a), 64'd2);
      step(1'b1, 32'h00A00193, 1'b1, 1'b0, 1'b0);
      chk("bp_head_third", 64'(reg_d_a), 64'd3);
      chk("bp_third_valid", 64'(out_valid_a), 64'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Flush with OR and SK full and a bad word on the input
      step(1'b1, 32'h00A00093, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);
      sv_a = bad_count_a;
      sv_b = bad_count_b;
      step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
      chk("flush_out_valid", 64'(out_valid_a), 64'd0);
      chk("flush_in_ready", 64'(in_ready_a), 64'd1);
      chk("flush_count_a", 64'(bad_count_a), 64'(sv_a));
      chk("flush_count_b", 64'(bad_count_b), 64'(sv_b));

      // Flush while a bad word is really accepted (only OR occupied)
      step(1'b1, 32'h00A00093, 1'b0, 1'b0, 1'b0);
      sv_a = bad_count_a;
      step(1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
      chk("flush_acc_valid", 64'(out_valid_a), 64'd0);
      chk("flush_acc_count", 64'(bad_count_a), 64'(sv_a));

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 3) != 0), rand_inst(),
              1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 49) == 0),
              1'($urandom_range(0, 199) == 0));
      end

      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      chk("drain_empty", 64'(out_valid_a), 64'd0);

      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
